nios2_control_debug_ocimem_ctrl: RTL
====================================

NIOS2_CONTROL_DEBUG_OCIMEM_CTRL -- requirements
Module: nios2_control_debug_ocimem_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 8, giving the debug RAM word-address width (256 x 32-bit words).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port jdo, input, 38 bits: the JTAG command/data word, sampled only when an action strobe is high.
REQ-005 SHALL have ports take_action_ocimem_a, take_no_action_ocimem_a and take_action_ocimem_b, input, 1 bit each: single-cycle JTAG command strobes.
REQ-006 SHALL have CPU slave inputs: address (RAM_AW bits), chipselect, read, write, debugaccess (1 bit each), writedata (32 bits), byteenable (4 bits).
REQ-007 SHALL have CPU slave outputs: readdata (32 bits), registered, and waitrequest (1 bit).
REQ-008 SHALL have port MonDReg, output, 32 bits: the JTAG data register, returned on the JTAG scan path.
REQ-009 SHALL have port MonAReg, output, RAM_AW bits: the current JTAG word address.
REQ-010 SHALL have port monitor_ready, output, 1 bit: high when no JTAG RAM access is pending.

Function
REQ-011 SHALL hold one single-port 2^RAM_AW x 32 RAM shared by the CPU and JTAG sides; at most one access per cycle.
REQ-012 On take_action_ocimem_a: MonAReg <= jdo[25:18]; if jdo[35]=1, a JTAG read is queued (MonRd=1); MonWr <= 0.
REQ-013 On take_no_action_ocimem_a: MonAReg <= MonAReg+1 (wraps modulo 2^RAM_AW) and a JTAG read is queued.
REQ-014 On take_action_ocimem_b: MonDReg <= jdo[34:3] and a JTAG write to MonAReg is queued (MonWr=1).
REQ-015 Strobes arriving while MonRd or MonWr is set SHALL overwrite the pending request; the last strobe wins; no queue depth beyond 1.
REQ-016 FSM states: IDLE, JRD, JRD_CAP, JWR; reset state IDLE.
REQ-017 IDLE -> JWR when MonWr=1 and no CPU access this cycle; IDLE -> JRD when MonRd=1, MonWr=0 and no CPU access; otherwise stay in IDLE.
REQ-018 JRD: issue the RAM read at MonAReg; -> JRD_CAP. JRD_CAP: MonDReg <= RAM data, clear MonRd; -> IDLE.
REQ-019 JWR: write MonDReg to all 4 bytes; clear MonWr; MonAReg <= MonAReg+1 (wrap); -> IDLE.
REQ-020 A CPU access is chipselect & (read|write); in IDLE it SHALL win arbitration over a pending JTAG request.
REQ-021 In JRD, JRD_CAP and JWR the CPU access SHALL be stalled: waitrequest=1 and no RAM effect.
REQ-022 CPU read in IDLE: waitrequest=1 in the first cycle; readdata valid and waitrequest=0 in the second cycle (1-cycle latency); the FSM SHALL NOT leave IDLE in either cycle.
REQ-023 CPU write in IDLE: completes in the same cycle with waitrequest=0; only bytes with byteenable=1 are written, and only if debugaccess=1; otherwise the write is silently dropped but still completes.
REQ-024 monitor_ready = ~(MonRd|MonWr), combinational from the registered flags.
REQ-025 read and write asserted together: write takes precedence and read is ignored.

Reset
REQ-026 While reset is high: FSM=IDLE, MonAReg=0, MonDReg=0, MonRd=MonWr=0, readdata=0, waitrequest=0, monitor_ready=1; RAM contents unspecified.
REQ-027 Reset asserted mid-access SHALL abort the access: a JWR aborted before its clock edge does not write; a pending JTAG request is lost.

Verification
REQ-028 ocimem_b with jdo[34:3]=0xDEADBEEF after ocimem_a (jdo[25:18]=0x10, jdo[35]=0) -> RAM[0x10]=0xDEADBEEF; MonAReg=0x11; monitor_ready returns to 1 within 2 cycles.
REQ-029 ocimem_a with addr 0x10 and jdo[35]=1 -> MonDReg=0xDEADBEEF 3 cycles after the strobe; then take_no_action_ocimem_a -> MonAReg=0x11, MonDReg=RAM[0x11].
REQ-030 MonAReg=0xFF, then take_no_action_ocimem_a -> MonAReg=0x00 (wrap); a JWR at 0xFF -> MonAReg=0x00.
REQ-031 Continuous CPU reads with a JTAG read pending -> JTAG waits; on CPU idle the JTAG read completes; the CPU read issued during JRD sees waitrequest=1 until IDLE.
REQ-032 CPU write of 0x11223344, byteenable=0101, debugaccess=1 to a word holding 0 -> word=0x00220044; same write with debugaccess=0 -> word unchanged, waitrequest=0.
REQ-033 Reset pulsed in JWR -> RAM unchanged, MonAReg=0, monitor_ready=1 on the next cycle.

Source files
------------

// File: rtl/nios2_control_debug_ocimem_ctrl.sv
// Debug on-chip memory controller: one 32-bit single-port RAM shared by the
// CPU slave port and the JTAG monitor path, with CPU priority while idle.
module nios2_control_debug_ocimem_ctrl #(
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [RAM_AW-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic              debugaccess,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic [RAM_AW-1:0] MonAReg,
  output logic              monitor_ready
);

  typedef enum logic [1:0] {IDLE, JRD, JRD_CAP, JWR} state_t;

  state_t            state, state_next;
  logic              mon_rd, mon_wr;
  logic              rd_phase, rd_phase_next;
  logic              cpu_access, cpu_wr, cpu_rd;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;
  logic [31:0]       mem [0:(1<<RAM_AW)-1];
  logic              unused_jdo;

  assign unused_jdo    = ^{jdo[37:36], jdo[2:0]};
  assign cpu_access    = chipselect & (read | write);
  assign cpu_wr        = chipselect & write;
  assign cpu_rd        = chipselect & read & ~write;
  assign monitor_ready = ~(mon_rd | mon_wr);
  // Read data only drives the bus during the completing cycle of a CPU read.
  assign readdata      = rd_phase ? ram_q : 32'h0;

  always_comb begin
    state_next    = state;
    rd_phase_next = 1'b0;
    ram_we        = 1'b0;
    ram_be        = 4'hF;
    ram_addr      = address;
    ram_wdata     = writedata;
    waitrequest   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_wr) begin
          ram_we = debugaccess;
          ram_be = byteenable;
        end else if (cpu_rd) begin
          rd_phase_next = ~rd_phase;
          waitrequest   = ~rd_phase;
        end else if (mon_wr) begin
          state_next = JWR;
        end else if (mon_rd) begin
          state_next = JRD;
        end
      end
      JRD: begin
        ram_addr    = MonAReg;
        waitrequest = cpu_access;
        state_next  = JRD_CAP;
      end
      JRD_CAP: begin
        waitrequest = cpu_access;
        state_next  = IDLE;
      end
      JWR: begin
        ram_addr    = MonAReg;
        ram_wdata   = MonDReg;
        ram_we      = 1'b1;
        waitrequest = cpu_access;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A write landing on the edge that reset is held across must not reach the RAM.
    if (reset) begin
      ram_we      = 1'b0;
      waitrequest = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we && ram_be[b]) begin
        mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rd_phase <= 1'b0;
      mon_rd   <= 1'b0;
      mon_wr   <= 1'b0;
      MonAReg  <= '0;
      MonDReg  <= 32'h0;
    end else begin
      state    <= state_next;
      rd_phase <= rd_phase_next;
      case (state)
        JRD_CAP: begin
          // Skip the capture if a write strobe replaced the read in flight.
          if (mon_rd) MonDReg <= ram_q;
          mon_rd <= 1'b0;
        end
        JWR: begin
          mon_wr  <= 1'b0;
          MonAReg <= MonAReg + RAM_AW'(1);
        end
        default: ;
      endcase
      if (take_action_ocimem_a) begin
        MonAReg <= jdo[18 +: RAM_AW];
        mon_rd  <= jdo[35];
        mon_wr  <= 1'b0;
      end
      if (take_no_action_ocimem_a) begin
        MonAReg <= MonAReg + RAM_AW'(1);
        mon_rd  <= 1'b1;
        mon_wr  <= 1'b0;
      end
      if (take_action_ocimem_b) begin
        MonDReg <= jdo[34:3];
        mon_wr  <= 1'b1;
        mon_rd  <= 1'b0;
      end
    end
  end

endmodule
